uvmt_mio_cli_st_link_chkr: RTL and testbench

Parametrised, synthesisable link checker for the Moore.io CLI Self-Test DUT wrapper, bound alongside the DUT between the bob (ingress) and alice (egress) valid/ready streams. It records every bob-side beat in a per-channel expected queue, compares each alice-side beat against the queue head in order, and measures head-of-queue latency. Errors are reported as sticky flags and counters. This replaces a single-pair, assertion-only checker with N channels, configurable width, depth and latency budget, and an in-order scoreboard.

---
 rtl/uvmt_mio_cli_st_link_chkr.sv | 169 ++++++++++++++++
 tb/tb_uvmt_mio_cli_st_link_chkr.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uvmt_mio_cli_st_link_chkr.sv
// In-order link checker between the bob (ingress) and alice (egress) valid/ready streams.
// Each channel keeps an expected-beat queue, a head-of-queue age counter and sticky error flags.
module uvmt_mio_cli_st_link_chkr #(
  parameter int NUM_CH  = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_LAT = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  clr,
  input  logic [NUM_CH-1:0]                     bob_vld,
  input  logic [NUM_CH-1:0]                     bob_rdy,
  input  logic [NUM_CH*DATA_W-1:0]              bob_data,
  input  logic [NUM_CH-1:0]                     alice_vld,
  input  logic [NUM_CH-1:0]                     alice_rdy,
  input  logic [NUM_CH*DATA_W-1:0]              alice_data,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   outstanding,
  output logic [NUM_CH-1:0]                     err_mismatch,
  output logic [NUM_CH-1:0]                     err_unexp,
  output logic [NUM_CH-1:0]                     err_ovf,
  output logic [NUM_CH-1:0]                     err_tmo,
  output logic                                  err_any,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] first_err_ch,
  output logic [31:0]                           match_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(MAX_LAT + 1);
  localparam int FW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PW-1:0]     wr_ptr   [NUM_CH];
  logic [PW-1:0]     rd_ptr   [NUM_CH];
  logic [CW-1:0]     cnt      [NUM_CH];
  logic [LW-1:0]     age      [NUM_CH];
  logic [PW-1:0]     wr_ptr_n [NUM_CH];
  logic [PW-1:0]     rd_ptr_n [NUM_CH];
  logic [CW-1:0]     cnt_n    [NUM_CH];
  logic [LW-1:0]     age_n    [NUM_CH];

  logic [NUM_CH-1:0] push, ev_mis, ev_unexp, ev_ovf, ev_tmo, ev_match, ev_all;
  logic [NUM_CH-1:0] mis_n, unexp_n, ovf_n, tmo_n;
  logic [FW-1:0]     first_n;
  logic [31:0]       match_n;
  logic [32:0]       msum;

  always_comb begin
    push     = '0;
    ev_mis   = '0;
    ev_unexp = '0;
    ev_ovf   = '0;
    ev_tmo   = '0;
    ev_match = '0;
    msum     = {1'b0, match_cnt};
    for (int c = 0; c < NUM_CH; c++) begin
      logic in_hs, out_hs, full, empty, pop;
      logic [DATA_W-1:0] b, a, head;
      in_hs  = bob_vld[c] & bob_rdy[c];
      out_hs = alice_vld[c] & alice_rdy[c];
      b      = bob_data[c*DATA_W +: DATA_W];
      a      = alice_data[c*DATA_W +: DATA_W];
      head   = mem[c][rd_ptr[c]];
      full   = (cnt[c] == CW'(DEPTH));
      empty  = (cnt[c] == '0);
      pop    = out_hs & ~empty;
      // A same-cycle push/pop on an empty queue is a bypass: compare directly, store nothing.
      push[c] = in_hs & (~full | out_hs) & ~(empty & out_hs);
      ev_ovf[c] = in_hs & full & ~out_hs;
      if (pop) begin
        ev_match[c] = (head == a);
        ev_mis[c]   = (head != a);
      end else if (out_hs && in_hs) begin
        ev_match[c] = (b == a);
        ev_mis[c]   = (b != a);
      end else if (out_hs) begin
        ev_unexp[c] = 1'b1;
      end else begin
        ev_match[c] = 1'b0;
      end
      wr_ptr_n[c] = push[c] ? wr_ptr[c] + PW'(1) : wr_ptr[c];
      rd_ptr_n[c] = pop ? rd_ptr[c] + PW'(1) : rd_ptr[c];
      cnt_n[c]    = cnt[c] + (push[c] ? CW'(1) : CW'(0)) - (pop ? CW'(1) : CW'(0));
      // Age counts only while a beat sits at the head; a fresh push starts counting next cycle.
      if (pop || empty || clr) begin
        age_n[c] = '0;
      end else if (age[c] < LW'(MAX_LAT)) begin
        age_n[c] = age[c] + LW'(1);
      end else begin
        age_n[c] = age[c];
      end
      ev_tmo[c] = (age_n[c] == LW'(MAX_LAT)) && (age[c] != LW'(MAX_LAT)) && !clr;
      if (ev_match[c]) begin
        msum = msum + 33'd1;
      end else begin
        msum = msum;
      end
    end
    ev_all  = ev_mis | ev_unexp | ev_ovf | ev_tmo;
    mis_n   = clr ? '0 : (err_mismatch | ev_mis);
    unexp_n = clr ? '0 : (err_unexp | ev_unexp);
    ovf_n   = clr ? '0 : (err_ovf | ev_ovf);
    tmo_n   = clr ? '0 : (err_tmo | ev_tmo);
    match_n = clr ? 32'd0 : (msum[32] ? 32'hFFFF_FFFF : msum[31:0]);
    first_n = clr ? '0 : first_err_ch;
    if (!clr && !err_any) begin
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (ev_all[c]) begin
          first_n = FW'(c);
        end else begin
          first_n = first_n;
        end
      end
    end else begin
      first_n = first_n;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
        age[c]    <= '0;
      end
      err_mismatch <= '0;
      err_unexp    <= '0;
      err_ovf      <= '0;
      err_tmo      <= '0;
      err_any      <= 1'b0;
      first_err_ch <= '0;
      match_cnt    <= 32'd0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= wr_ptr_n[c];
        rd_ptr[c] <= rd_ptr_n[c];
        cnt[c]    <= cnt_n[c];
        age[c]    <= age_n[c];
      end
      err_mismatch <= mis_n;
      err_unexp    <= unexp_n;
      err_ovf      <= ovf_n;
      err_tmo      <= tmo_n;
      err_any      <= |{mis_n, unexp_n, ovf_n, tmo_n};
      first_err_ch <= first_n;
      match_cnt    <= match_n;
    end
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= bob_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      outstanding[c*CW +: CW] = cnt[c];
    end
  end

endmodule

// File: tb/tb_uvmt_mio_cli_st_link_chkr.sv
// Directed bench for uvmt_mio_cli_st_link_chkr with NUM_CH=2, DATA_W=32, DEPTH=8, MAX_LAT=16.
module tb_uvmt_mio_cli_st_link_chkr;

  logic        clk = 1'b0;
  logic        reset, clr;
  logic [1:0]  bob_vld, bob_rdy, alice_vld, alice_rdy;
  logic [63:0] bob_data, alice_data;
  logic [7:0]  outstanding;
  logic [1:0]  err_mismatch, err_unexp, err_ovf, err_tmo;
  logic        err_any;
  logic [0:0]  first_err_ch;
  logic [31:0] match_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uvmt_mio_cli_st_link_chkr #(
    .NUM_CH(2), .DATA_W(32), .DEPTH(8), .MAX_LAT(16)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .bob_vld(bob_vld), .bob_rdy(bob_rdy), .bob_data(bob_data),
    .alice_vld(alice_vld), .alice_rdy(alice_rdy), .alice_data(alice_data),
    .outstanding(outstanding), .err_mismatch(err_mismatch), .err_unexp(err_unexp),
    .err_ovf(err_ovf), .err_tmo(err_tmo), .err_any(err_any),
    .first_err_ch(first_err_ch), .match_cnt(match_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of handshakes: bv/av are per-channel handshake masks.
  task automatic xfer(input logic [1:0] bv, input logic [31:0] b0, input logic [31:0] b1,
                      input logic [1:0] av, input logic [31:0] a0, input logic [31:0] a1);
    bob_vld = bv; bob_rdy = bv; bob_data = {b1, b0};
    alice_vld = av; alice_rdy = av; alice_data = {a1, a0};
    step();
    bob_vld = 2'b00; bob_rdy = 2'b00; alice_vld = 2'b00; alice_rdy = 2'b00;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0;
    bob_vld = '0; bob_rdy = '0; bob_data = '0;
    alice_vld = '0; alice_rdy = '0; alice_data = '0;
    step(); step();
    reset = 1'b0;
    check("rst_outstanding", outstanding, 8'h00);
    check("rst_err_any", err_any, 1'b0);
    check("rst_match", match_cnt, 32'd0);
    check("rst_first", first_err_ch, 1'b0);

    // In-order matches on ch0.
    for (int i = 1; i <= 4; i++) xfer(2'b01, 32'hA5A5_0000 + i, 32'd0, 2'b00, 32'd0, 32'd0);
    check("t1_outstanding4", outstanding[3:0], 4'd4);
    for (int i = 1; i <= 4; i++) xfer(2'b00, 32'd0, 32'd0, 2'b01, 32'hA5A5_0000 + i, 32'd0);
    check("t1_match", match_cnt, 32'd4);
    check("t1_outstanding0", outstanding[3:0], 4'd0);
    check("t1_err_any", err_any, 1'b0);

    // Out-of-order pop on ch1.
    xfer(2'b10, 32'd0, 32'h0000_1234, 2'b00, 32'd0, 32'd0);
    xfer(2'b10, 32'd0, 32'h0000_5678, 2'b00, 32'd0, 32'd0);
    check("t2_no_err_yet", err_any, 1'b0);
    xfer(2'b00, 32'd0, 32'd0, 2'b10, 32'd0, 32'h0000_5678);
    check("t2_mismatch", err_mismatch, 2'b10);
    check("t2_first", first_err_ch, 1'b1);
    check("t2_err_any", err_any, 1'b1);
    check("t2_ch0_flags", {err_unexp[0], err_ovf[0], err_tmo[0]}, 3'b000);
    check("t2_match_hold", match_cnt, 32'd4);
    xfer(2'b00, 32'd0, 32'd0, 2'b10, 32'd0, 32'h0000_5678);
    check("t2_match_next", match_cnt, 32'd5);
    check("t2_outstanding1", outstanding[7:4], 4'd0);
    do_clr();
    check("t2_clr_err", {err_mismatch, err_any}, 3'b000);
    check("t2_clr_match", match_cnt, 32'd0);

    // Overflow on ch0.
    for (int i = 0; i < 8; i++) xfer(2'b01, 32'h100 + i, 32'd0, 2'b00, 32'd0, 32'd0);
    check("t3_full", outstanding[3:0], 4'd8);
    check("t3_no_ovf", err_ovf, 2'b00);
    xfer(2'b01, 32'h108, 32'd0, 2'b00, 32'd0, 32'd0);
    check("t3_ovf", err_ovf, 2'b01);
    check("t3_full_kept", outstanding[3:0], 4'd8);
    do_clr();
    xfer(2'b01, 32'h109, 32'd0, 2'b01, 32'h100, 32'd0);
    check("t3_full_pushpop_ovf", err_ovf, 2'b00);
    check("t3_full_pushpop_occ", outstanding[3:0], 4'd8);
    check("t3_full_pushpop_match", match_cnt, 32'd1);
    for (int i = 1; i < 8; i++) xfer(2'b00, 32'd0, 32'd0, 2'b01, 32'h100 + i, 32'd0);
    xfer(2'b00, 32'd0, 32'd0, 2'b01, 32'h109, 32'd0);
    check("t3_drain_match", match_cnt, 32'd9);
    check("t3_drain_occ", outstanding[3:0], 4'd0);
    check("t3_drain_err", err_any, 1'b0);

    // Unexpected beat on ch0 and bypass on ch1.
    xfer(2'b00, 32'd0, 32'd0, 2'b01, 32'hDEAD, 32'd0);
    check("t4_unexp", err_unexp, 2'b01);
    check("t4_first", first_err_ch, 1'b0);
    xfer(2'b10, 32'd0, 32'h0000_BEEF, 2'b10, 32'd0, 32'h0000_BEEF);
    check("t4_bypass_match", match_cnt, 32'd10);
    check("t4_bypass_occ", outstanding[7:4], 4'd0);
    check("t4_bypass_mis", err_mismatch, 2'b00);
    do_clr();

    // Timeout on ch1: push at edge T, flag at edge T+16.
    xfer(2'b10, 32'd0, 32'h0000_0077, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 15; i++) step();
    check("t5_tmo_early", err_tmo, 2'b00);
    step();
    check("t5_tmo", err_tmo, 2'b10);
    check("t5_first", first_err_ch, 1'b1);
    check("t5_err_any", err_any, 1'b1);
    do_clr();
    check("t5_clr_err", {err_tmo, err_mismatch, err_unexp, err_ovf, err_any}, 9'd0);
    check("t5_clr_first", first_err_ch, 1'b0);
    check("t5_clr_match", match_cnt, 32'd0);
    check("t5_clr_occ", outstanding[7:4], 4'd1);

    // Reset mid-stream drops expectations.
    for (int i = 0; i < 3; i++) xfer(2'b01, 32'h300 + i, 32'd0, 2'b00, 32'd0, 32'd0);
    check("t6_pre_occ", outstanding[3:0], 4'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_occ", outstanding, 8'h00);
    xfer(2'b00, 32'd0, 32'd0, 2'b01, 32'h300, 32'd0);
    check("t6_unexp", err_unexp, 2'b01);
    check("t6_err_any", err_any, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
